// File: rtl/iob_ram_2p.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | iob_ram_2p : simple dual-port RAM, one write port and one registered read  |
// |              port; read data is held while r_en_i is low.                  |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
module iob_ram_2p #(
   parameter        HEXFILE = "none",
   parameter int    DATA_W  = 8,
   parameter int    ADDR_W  = 4
) (
   input  logic              clk_i,
   input  logic              w_en_i,
   input  logic [ADDR_W-1:0] w_addr_i,
   input  logic [DATA_W-1:0] w_data_i,
   input  logic              r_en_i,
   input  logic [ADDR_W-1:0] r_addr_i,
   output logic [DATA_W-1:0] r_data_o
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rdata;

   always_ff @(posedge clk_i) begin
      if (w_en_i) r_mem[w_addr_i] <= w_data_i;
      if (r_en_i) r_rdata <= r_mem[r_addr_i];
   end

   // Preloading belongs to the simulation-only variant; this model always starts blank.
   if (HEXFILE == "none") begin : g_blank
      assign r_data_o = r_rdata;
   end else begin : g_preload_unsupported
      assign r_data_o = r_rdata;
   end

endmodule
`default_nettype wire

// File: rtl/iob_ram_2p_fifo_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | iob_ram_2p_fifo_ctrl : FWFT FIFO controller driving an external two-port   |
// |                        RAM with a registered, data-holding read port.      |
// | Revision             : 1.0                                                 |
// +----------------------------------------------------------------------------+
module iob_ram_2p_fifo_ctrl #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk_i,
   input  logic              arst_n_i,
   input  logic              w_valid_i,
   input  logic [DATA_W-1:0] w_data_i,
   output logic              w_ready_o,
   output logic              r_valid_o,
   output logic [DATA_W-1:0] r_data_o,
   input  logic              r_ready_i,
   output logic [ADDR_W:0]   level_o,
   output logic              ext_mem_w_en_o,
   output logic [ADDR_W-1:0] ext_mem_w_addr_o,
   output logic [DATA_W-1:0] ext_mem_w_data_o,
   output logic              ext_mem_r_en_o,
   output logic [ADDR_W-1:0] ext_mem_r_addr_o,
   input  logic [DATA_W-1:0] ext_mem_r_data_i
);

   localparam int              DEPTH      = 2**ADDR_W;
   localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] ONE        = (ADDR_W+1)'(1);

   logic [ADDR_W:0] r_w_ptr;
   logic [ADDR_W:0] r_r_ptr;
   logic [ADDR_W:0] r_level;
   logic            r_out_valid;

   logic [ADDR_W:0] w_ram_count;
   logic            w_accept;
   logic            w_pop;
   logic            w_rd_issue;

   // Ready is gated by reset so the producer sees no acceptance while held in reset.
   assign w_ready_o   = arst_n_i & (r_level < FULL_LEVEL);
   assign w_accept    = w_valid_i & w_ready_o;
   assign w_pop       = r_out_valid & r_ready_i;

   // Registered pointers only: a read never targets the slot written this cycle.
   assign w_ram_count = r_w_ptr - r_r_ptr;
   assign w_rd_issue  = (w_ram_count != '0) & (~r_out_valid | r_ready_i);

   assign ext_mem_w_en_o   = w_accept;
   assign ext_mem_w_addr_o = r_w_ptr[ADDR_W-1:0];
   assign ext_mem_w_data_o = w_data_i;
   assign ext_mem_r_en_o   = w_rd_issue;
   assign ext_mem_r_addr_o = r_r_ptr[ADDR_W-1:0];

   assign r_valid_o = r_out_valid;
   assign r_data_o  = ext_mem_r_data_i;
   assign level_o   = r_level;

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         r_w_ptr     <= '0;
         r_r_ptr     <= '0;
         r_level     <= '0;
         r_out_valid <= 1'b0;
      end else begin
         if (w_accept)   r_w_ptr <= r_w_ptr + ONE;
         if (w_rd_issue) r_r_ptr <= r_r_ptr + ONE;

         if (w_rd_issue)     r_out_valid <= 1'b1;
         else if (r_ready_i) r_out_valid <= 1'b0;

         case ({w_accept, w_pop})
            2'b10:   r_level <= r_level + ONE;
            2'b01:   r_level <= r_level - ONE;
            default: r_level <= r_level;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_iob_ram_2p_fifo_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_iob_ram_2p_fifo_ctrl : directed vector table plus scoreboarded          |
// |                           sequences for the RAM-backed FIFO controller.    |
// | Revision                : 1.0                                              |
// +----------------------------------------------------------------------------+
module tb_iob_ram_2p_fifo_ctrl;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 2;
   localparam int DEPTH  = 4;

   logic              clk_i     = 1'b0;
   logic              arst_n_i  = 1'b0;
   logic              w_valid_i = 1'b0;
   logic [DATA_W-1:0] w_data_i  = '0;
   logic              r_ready_i = 1'b0;
   logic              w_ready_o;
   logic              r_valid_o;
   logic [DATA_W-1:0] r_data_o;
   logic [ADDR_W:0]   level_o;
   logic              mem_w_en;
   logic [ADDR_W-1:0] mem_w_addr;
   logic [DATA_W-1:0] mem_w_data;
   logic              mem_r_en;
   logic [ADDR_W-1:0] mem_r_addr;
   logic [DATA_W-1:0] mem_r_data;

   always #5 clk_i = ~clk_i;

   iob_ram_2p_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_dut (
      .clk_i            (clk_i),
      .arst_n_i         (arst_n_i),
      .w_valid_i        (w_valid_i),
      .w_data_i         (w_data_i),
      .w_ready_o        (w_ready_o),
      .r_valid_o        (r_valid_o),
      .r_data_o         (r_data_o),
      .r_ready_i        (r_ready_i),
      .level_o          (level_o),
      .ext_mem_w_en_o   (mem_w_en),
      .ext_mem_w_addr_o (mem_w_addr),
      .ext_mem_w_data_o (mem_w_data),
      .ext_mem_r_en_o   (mem_r_en),
      .ext_mem_r_addr_o (mem_r_addr),
      .ext_mem_r_data_i (mem_r_data)
   );

   iob_ram_2p #(.HEXFILE("none"), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
      .clk_i    (clk_i),
      .w_en_i   (mem_w_en),
      .w_addr_i (mem_w_addr),
      .w_data_i (mem_w_data),
      .r_en_i   (mem_r_en),
      .r_addr_i (mem_r_addr),
      .r_data_o (mem_r_data)
   );

   typedef struct packed {
      logic       wv;
      logic [7:0] wd;
      logic       rr;
      logic       wrdy;
      logic       rv;
      logic [7:0] rd;
      logic [2:0] lvl;
      logic       wen;
      logic       ren;
   } vec_t;

   int n_pass  = 0;
   int n_total = 0;

   logic [DATA_W-1:0] q[$];
   int                m_wa, m_ra, n_in, n_out;
   logic              hold;
   logic [DATA_W-1:0] hold_data;
   logic              last_rvalid;
   logic [ADDR_W:0]   last_level;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
   endtask

   function automatic vec_t mk(input logic wv, input logic [7:0] wd, input logic rr,
                               input logic wrdy, input logic rv, input logic [7:0] rd,
                               input logic [2:0] lvl, input logic wen, input logic ren);
      vec_t v;
      v.wv = wv; v.wd = wd; v.rr = rr; v.wrdy = wrdy; v.rv = rv;
      v.rd = rd; v.lvl = lvl; v.wen = wen; v.ren = ren;
      return v;
   endfunction

   task automatic sb_reset();
      q.delete();
      m_wa = 0; m_ra = 0; hold = 1'b0; hold_data = '0;
   endtask

   // One cycle against the scoreboard: inputs at negedge, outputs sampled 1 time unit later.
   task automatic sb_step(input logic wv, input logic [DATA_W-1:0] wd, input logic rr);
      logic exp_wen;
      @(negedge clk_i);
      w_valid_i = wv; w_data_i = wd; r_ready_i = rr;
      #1;
      exp_wen = wv && (q.size() < DEPTH);
      check("sb_level",   32'(level_o),   32'(q.size()));
      check("sb_w_ready", 32'(w_ready_o), 32'(q.size() < DEPTH));
      check("sb_w_en",    32'(mem_w_en),  32'(exp_wen));
      if (hold) begin
         check("hold_valid", 32'(r_valid_o), 32'd1);
         check("hold_data",  32'(r_data_o),  32'(hold_data));
      end
      if (mem_r_en) begin
         check("r_addr", 32'(mem_r_addr), 32'(m_ra % DEPTH));
         check("rw_same_slot", 32'(mem_w_en && (mem_w_addr == mem_r_addr)), 32'd0);
         m_ra++;
      end
      if (r_valid_o && rr) begin
         if (q.size() == 0) check("pop_from_empty", 32'd1, 32'd0);
         else check("pop_data", 32'(r_data_o), 32'(q.pop_front()));
         n_out++;
      end
      if (mem_w_en) begin
         check("w_addr", 32'(mem_w_addr), 32'(m_wa % DEPTH));
         check("w_data", 32'(mem_w_data), 32'(wd));
         m_wa++;
         n_in++;
         q.push_back(wd);
      end
      hold        = r_valid_o && !rr;
      hold_data   = r_data_o;
      last_rvalid = r_valid_o;
      last_level  = level_o;
   endtask

   task automatic drain(input string name);
      int guard;
      guard = 0;
      while (q.size() != 0 && guard < 20) begin
         sb_step(1'b0, '0, 1'b1);
         guard++;
      end
      check(name, 32'(q.size()), 32'd0);
   endtask

   initial begin
      vec_t tbl[14];
      logic [15:0] act, exp;
      logic [7:0]  d;

      tbl[0]  = mk(1'b1, 8'hA5, 1'b0,  1'b1, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0);
      tbl[1]  = mk(1'b0, 8'h00, 1'b0,  1'b1, 1'b0, 8'h00, 3'd1, 1'b0, 1'b1);
      tbl[2]  = mk(1'b0, 8'h00, 1'b1,  1'b1, 1'b1, 8'hA5, 3'd1, 1'b0, 1'b0);
      tbl[3]  = mk(1'b0, 8'h00, 1'b0,  1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
      tbl[4]  = mk(1'b1, 8'h10, 1'b0,  1'b1, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0);
      tbl[5]  = mk(1'b1, 8'h11, 1'b0,  1'b1, 1'b0, 8'h00, 3'd1, 1'b1, 1'b1);
      tbl[6]  = mk(1'b1, 8'h12, 1'b0,  1'b1, 1'b1, 8'h10, 3'd2, 1'b1, 1'b0);
      tbl[7]  = mk(1'b1, 8'h13, 1'b0,  1'b1, 1'b1, 8'h10, 3'd3, 1'b1, 1'b0);
      tbl[8]  = mk(1'b1, 8'h14, 1'b0,  1'b0, 1'b1, 8'h10, 3'd4, 1'b0, 1'b0);
      tbl[9]  = mk(1'b1, 8'h14, 1'b1,  1'b0, 1'b1, 8'h10, 3'd4, 1'b0, 1'b1);
      tbl[10] = mk(1'b0, 8'h00, 1'b1,  1'b1, 1'b1, 8'h11, 3'd3, 1'b0, 1'b1);
      tbl[11] = mk(1'b0, 8'h00, 1'b1,  1'b1, 1'b1, 8'h12, 3'd2, 1'b0, 1'b1);
      tbl[12] = mk(1'b0, 8'h00, 1'b1,  1'b1, 1'b1, 8'h13, 3'd1, 1'b0, 1'b0);
      tbl[13] = mk(1'b0, 8'h00, 1'b0,  1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);

      n_in = 0; n_out = 0; last_rvalid = 1'b0; last_level = '0;
      sb_reset();

      // Power-on reset
      w_valid_i = 1'b1;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      check("por_w_ready", 32'(w_ready_o), 32'd0);
      check("por_r_valid", 32'(r_valid_o), 32'd0);
      check("por_level",   32'(level_o),   32'd0);
      check("por_w_en",    32'(mem_w_en),  32'd0);
      w_valid_i = 1'b0;
      arst_n_i  = 1'b1;
      #1;
      check("por_release_w_ready", 32'(w_ready_o), 32'd1);

      // Directed table: single word, fill, overflow, drain
      for (int i = 0; i < 14; i++) begin
         @(negedge clk_i);
         w_valid_i = tbl[i].wv; w_data_i = tbl[i].wd; r_ready_i = tbl[i].rr;
         #1;
         act = {w_ready_o, r_valid_o, (r_valid_o ? r_data_o : 8'h00), level_o, mem_w_en, mem_r_en};
         exp = {tbl[i].wrdy, tbl[i].rv, (tbl[i].rv ? tbl[i].rd : 8'h00), tbl[i].lvl, tbl[i].wen, tbl[i].ren};
         check($sformatf("vec%0d{wrdy,rv,rd,lvl,wen,ren}", i), 32'(act), 32'(exp));
      end

      // Streaming: continuous write and read
      sb_reset();
      m_wa = 1; m_ra = 1;
      for (int i = 0; i < 20; i++) begin
         sb_step(1'b1, 8'(8'h20 + i), 1'b1);
         if (i >= 2) check("stream_r_valid", 32'(last_rvalid), 32'd1);
         check("stream_level_le2", 32'(last_level <= 3'd2), 32'd1);
      end
      drain("stream_drain");

      // Reset mid-operation with 3 words held
      for (int i = 0; i < 3; i++) sb_step(1'b1, 8'(8'h60 + i), 1'b0);
      @(negedge clk_i);
      arst_n_i = 1'b0; w_valid_i = 1'b1; r_ready_i = 1'b1;
      #1;
      check("rst_w_ready", 32'(w_ready_o), 32'd0);
      check("rst_r_valid", 32'(r_valid_o), 32'd0);
      check("rst_level",   32'(level_o),   32'd0);
      check("rst_w_en",    32'(mem_w_en),  32'd0);
      check("rst_r_en",    32'(mem_r_en),  32'd0);
      @(negedge clk_i);
      check("rst_hold_level", 32'(level_o), 32'd0);
      arst_n_i = 1'b1; w_valid_i = 1'b0;
      #1;
      check("rst_release_w_ready", 32'(w_ready_o), 32'd1);
      sb_reset();
      for (int i = 0; i < 4; i++) begin
         sb_step(1'b0, '0, 1'b1);
         check("no_stale_word", 32'(last_rvalid), 32'd0);
      end

      // Random backpressure and stalls; pointers wrap several times
      n_in = 0;
      for (int i = 0; i < 80; i++) begin
         d = 8'($urandom);
         sb_step(($urandom_range(0, 3) != 0), d, ($urandom_range(0, 1) == 1));
      end
      drain("random_drain");
      check("wrap_enough_words", 32'(n_in >= 10), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running, required finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/iob_ram_2p_fifo_ctrl.md
Name: iob_ram_2p_fifo_ctrl

Overview:
Synchronous FIFO controller that drives both ports of an external two-port RAM (iob_ram_2p: registered read, 1-cycle latency, read data held while r_en low). It accepts a valid/ready write stream, turns it into RAM writes, issues RAM reads, and presents a first-word-fall-through valid/ready read stream. Sits between a producer and a consumer wherever the cache needs RAM-backed buffering; the RAM itself is instanced by the parent.

Parameters:
DATA_W, 8, word width
ADDR_W, 4, RAM address width; capacity DEPTH = 2**ADDR_W words

Ports:
clk_i  in  1  clock, all state on rising edge
arst_n_i  in  1  asynchronous active-low reset
w_valid_i  in  1  producer has a word
w_data_i  in  DATA_W  producer word
w_ready_o  out  1  controller accepts word this cycle
r_valid_o  out  1  r_data_o holds a valid word
r_data_o  out  DATA_W  head word
r_ready_i  in  1  consumer takes word this cycle
level_o  out  ADDR_W+1  words held (in RAM plus presented), 0..DEPTH
ext_mem_w_en_o  out  1  RAM write enable
ext_mem_w_addr_o  out  ADDR_W  RAM write address
ext_mem_w_data_o  out  DATA_W  RAM write data
ext_mem_r_en_o  out  1  RAM read enable
ext_mem_r_addr_o  out  ADDR_W  RAM read address
ext_mem_r_data_i  in  DATA_W  RAM registered read data

Behaviour:
- State: w_ptr, r_ptr (ADDR_W+1 bits, wrap modulo 2*DEPTH), out_valid flag, level counter. All reset asynchronously to 0.
- While arst_n_i low: w_ready_o=0, r_valid_o=0, level_o=0, ext_mem_w_en_o=0, ext_mem_r_en_o=0. After release: w_ready_o=1.
- w_ready_o = (level < DEPTH). Write accept = w_valid_i & w_ready_o -> ext_mem_w_en_o=1, w_addr = w_ptr[ADDR_W-1:0], w_data = w_data_i, w_ptr increments at the edge. w_valid_i with w_ready_o=0 is ignored, no state change.
- ram_count = w_ptr - r_ptr (registered pointers only). Read issue = (ram_count != 0) & (!out_valid | r_ready_i) -> ext_mem_r_en_o=1, r_addr = r_ptr[ADDR_W-1:0], r_ptr increments.
- out_valid next: 1 if read issued; else 0 if r_ready_i; else hold. r_valid_o = out_valid; r_data_o = ext_mem_r_data_i directly (RAM holds data while r_en low, so data is stable under backpressure).
- Pop = r_valid_o & r_ready_i. level next = level + accept - pop; simultaneous accept and pop leave level unchanged.
- Latency: word accepted at edge N is readable from RAM at N+1 (read issued cycle N+1 at earliest); r_valid_o rises cycle N+2. A read never targets the slot being written the same cycle, because ram_count uses registered w_ptr.
- Throughput: one write and one pop per cycle sustained.
- Full: level==DEPTH -> w_ready_o=0; a same-cycle pop does not raise w_ready_o that cycle (no combinational ready path).
- Empty: r_valid_o=0, ext_mem_r_en_o=0; r_ready_i is don't-care.
- Pointer wrap: addresses wrap DEPTH-1 -> 0; ordering is preserved.
- Reset mid-operation: all contents are discarded; RAM contents are left stale and are never read.

Decomposition:
- No shared package. DEPTH is a localparam derived from ADDR_W.
- No sub-module: pointer and flag logic only. The RAM stays external.
- The bench instantiates iob_ram_2p (HEXFILE "none") on the ext_mem_* ports.

Test Plan:
1. Reset: assert arst_n_i low mid-stream with 3 words held -> r_valid_o=0, level_o=0, w_ready_o=0 while low; w_ready_o=1 on the first cycle after release; no stale word appears.
2. Single word (DATA_W=8, ADDR_W=2): write 0xA5 at cycle 0 -> level_o=1 at cycle 1, ext_mem_r_en_o=1 at cycle 1, r_valid_o=1 with r_data_o=0xA5 at cycle 2; pop -> level_o=0.
3. Fill/overflow: r_ready_i=0, write 0x10,0x11,0x12,0x13 -> level_o=4, w_ready_o=0; a 5th write of 0x14 is ignored; draining yields 0x10..0x13 in order, then r_valid_o=0.
4. Streaming: w_valid_i=1 and r_ready_i=1 continuously with incrementing data -> after a 2-cycle fill, one word out per cycle in order and level_o stays <=2.
5. Backpressure: random r_ready_i -> r_data_o stable while r_valid_o&!r_ready_i; scoreboard shows no loss or duplication.
6. Wrap: pass 10 words through DEPTH=4 with interleaved stalls -> addresses wrap 3->0 and output order matches input exactly.
